// File: rtl/adc_ascii_framer.sv
`default_nettype none
// ============================================================================
// Module   : adc_ascii_framer
// Purpose  : Periodically snapshots every ADC channel, scales each code to
//            millivolts and streams one "Cnn=dddd " record per channel plus a
//            CR/LF terminator into a UART TX FIFO write port, one byte at a time.
// Revision : 1.0 - initial release
// ============================================================================
module adc_ascii_framer #(
    parameter int CHANNELS     = 13,
    parameter int DATA_W       = 12,
    parameter int VREF_MV      = 3300,
    parameter int FRAME_PERIOD = 6_500_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [CHANNELS*DATA_W-1:0] adc_in,
    input  logic                       tx_full,
    output logic [7:0]                 wr_data,
    output logic                       wr_uart,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       frame_missed
);

    localparam int c_cnt_w = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FRAME_PERIOD - 1);
    localparam logic [6:0]         c_last_ch  = 7'(CHANNELS - 1);
    localparam logic [13:0]        c_vref     = 14'(VREF_MV);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_latch  = 3'd1;
    localparam logic [2:0] c_st_scale  = 3'd2;
    localparam logic [2:0] c_st_digits = 3'd3;
    localparam logic [2:0] c_st_emit   = 3'd4;
    localparam logic [2:0] c_st_tail   = 3'd5;

    logic [c_cnt_w-1:0]         r_period_cnt;
    logic [2:0]                 r_state;
    logic [CHANNELS*DATA_W-1:0] r_snapshot;
    logic [6:0]                 r_ch;
    logic [13:0]                r_rem;       // mV remainder; ends as the units digit
    logic [6:0]                 r_idx_rem;   // channel index remainder; ends as units
    logic [3:0]                 r_d3;
    logic [3:0]                 r_d2;
    logic [3:0]                 r_d1;
    logic [3:0]                 r_nn_tens;
    logic [1:0]                 r_step;
    logic [3:0]                 r_byte_idx;
    logic                       r_wr_req;    // a byte is staged and waiting for FIFO room
    logic [7:0]                 r_wr_pend;   // staged byte
    logic [7:0]                 r_wr_last;   // last byte actually written
    logic                       r_busy;
    logic                       r_frame_done;
    logic                       r_frame_missed;

    logic                       w_trigger;
    logic [DATA_W-1:0]          w_code;
    logic [13:0]                w_mv;
    logic [7:0]                 w_emit_byte;
    logic [7:0]                 w_tail_byte;

    assign w_trigger = (r_period_cnt == c_cnt_last);
    assign w_code    = r_snapshot[int'(r_ch)*DATA_W +: DATA_W];
    // Full-width product so the truncating shift never loses high bits.
    assign w_mv      = 14'(({14'd0, w_code} * {{DATA_W{1'b0}}, c_vref}) >> DATA_W);

    // Free-running frame period counter; a trigger is the wrap back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else if (w_trigger) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + c_cnt_w'(1);
        end
    end

    // ASCII byte for the current position inside a channel record.
    always_comb begin
        w_emit_byte = 8'h20;
        case (r_byte_idx)
            4'd0:    w_emit_byte = 8'h43;                     // 'C'
            4'd1:    w_emit_byte = {4'h3, r_nn_tens};
            4'd2:    w_emit_byte = {4'h3, r_idx_rem[3:0]};
            4'd3:    w_emit_byte = 8'h3D;                     // '='
            4'd4:    w_emit_byte = {4'h3, r_d3};
            4'd5:    w_emit_byte = {4'h3, r_d2};
            4'd6:    w_emit_byte = {4'h3, r_d1};
            4'd7:    w_emit_byte = {4'h3, r_rem[3:0]};
            default: w_emit_byte = 8'h20;                     // ' '
        endcase
    end

    assign w_tail_byte = (r_byte_idx == 4'd0) ? 8'h0D : 8'h0A;

    // Frame sequencer: latch, scale, BCD-convert and emit each channel in turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_snapshot     <= '0;
            r_ch           <= '0;
            r_rem          <= '0;
            r_idx_rem      <= '0;
            r_d3           <= '0;
            r_d2           <= '0;
            r_d1           <= '0;
            r_nn_tens      <= '0;
            r_step         <= '0;
            r_byte_idx     <= '0;
            r_wr_req       <= 1'b0;
            r_wr_pend      <= '0;
            r_wr_last      <= '0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_missed <= 1'b0;
        end else begin
            r_frame_done   <= 1'b0;
            r_frame_missed <= w_trigger && r_busy;
            case (r_state)
                c_st_idle: begin
                    if (w_trigger && enable) begin
                        r_busy  <= 1'b1;
                        r_ch    <= '0;
                        r_state <= c_st_latch;
                    end
                end
                c_st_latch: begin
                    r_snapshot <= adc_in;
                    r_state    <= c_st_scale;
                end
                c_st_scale: begin
                    r_rem     <= w_mv;
                    r_idx_rem <= r_ch;
                    r_d3      <= '0;
                    r_d2      <= '0;
                    r_d1      <= '0;
                    r_nn_tens <= '0;
                    r_step    <= '0;
                    r_state   <= c_st_digits;
                end
                c_st_digits: begin
                    // One subtraction per cycle; a failed compare moves to the next place.
                    case (r_step)
                        2'd0: begin
                            if (r_rem >= 14'd1000) begin
                                r_rem <= r_rem - 14'd1000;
                                r_d3  <= r_d3 + 4'd1;
                            end else begin
                                r_step <= 2'd1;
                            end
                        end
                        2'd1: begin
                            if (r_rem >= 14'd100) begin
                                r_rem <= r_rem - 14'd100;
                                r_d2  <= r_d2 + 4'd1;
                            end else begin
                                r_step <= 2'd2;
                            end
                        end
                        2'd2: begin
                            if (r_rem >= 14'd10) begin
                                r_rem <= r_rem - 14'd10;
                                r_d1  <= r_d1 + 4'd1;
                            end else begin
                                r_step <= 2'd3;
                            end
                        end
                        default: begin
                            if (r_idx_rem >= 7'd10) begin
                                r_idx_rem <= r_idx_rem - 7'd10;
                                r_nn_tens <= r_nn_tens + 4'd1;
                            end else begin
                                r_step     <= 2'd0;
                                r_byte_idx <= '0;
                                r_state    <= c_st_emit;
                            end
                        end
                    endcase
                end
                c_st_emit: begin
                    // Staging takes a cycle, which gives the idle gap after every write.
                    if (!r_wr_req) begin
                        r_wr_pend <= w_emit_byte;
                        r_wr_req  <= 1'b1;
                    end else if (!tx_full) begin
                        r_wr_req  <= 1'b0;
                        r_wr_last <= r_wr_pend;
                        if (r_byte_idx == 4'd8) begin
                            r_byte_idx <= '0;
                            if (r_ch == c_last_ch) begin
                                r_state <= c_st_tail;
                            end else begin
                                r_ch    <= r_ch + 7'd1;
                                r_state <= c_st_scale;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 4'd1;
                        end
                    end
                end
                c_st_tail: begin
                    if (!r_wr_req) begin
                        r_wr_pend <= w_tail_byte;
                        r_wr_req  <= 1'b1;
                    end else if (!tx_full) begin
                        r_wr_req  <= 1'b0;
                        r_wr_last <= r_wr_pend;
                        if (r_byte_idx == 4'd1) begin
                            r_byte_idx   <= '0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= c_st_idle;
                        end else begin
                            r_byte_idx <= r_byte_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // The strobe is qualified by tx_full in the same cycle so a full FIFO is never written.
    assign wr_uart      = r_wr_req && !tx_full;
    assign wr_data      = wr_uart ? r_wr_pend : r_wr_last;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign frame_missed = r_frame_missed;

endmodule
`default_nettype wire
